// File: rtl/multiexp_cmd_pkg.sv
// Shared opcode encodings, word-field positions and FSM states for the multiexp command decoder.
// Optional illegal-word counter in the top is enabled by MULTIEXP_CMD_ERRCNT_EN.
package multiexp_cmd_pkg;

    localparam int WORD_W = 32;
    localparam int OP_W   = 6;
    localparam int ARG_W  = 24;
    localparam int CNT_W  = 16;

    localparam int OP_LOAD_ERAM     = 0;
    localparam int OP_LOAD_TRAM     = 1;
    localparam int OP_SET_ADDR      = 2;
    localparam int OP_READ_RESULT   = 3;
    localparam int OP_FLUSH_RESULTS = 4;
    localparam int OP_START_MULT    = 5;

    localparam logic [OP_W-1:0] OPC_LOAD_ERAM     = 6'b000001;
    localparam logic [OP_W-1:0] OPC_LOAD_TRAM     = 6'b000010;
    localparam logic [OP_W-1:0] OPC_SET_ADDR      = 6'b000100;
    localparam logic [OP_W-1:0] OPC_READ_RESULT   = 6'b001000;
    localparam logic [OP_W-1:0] OPC_FLUSH_RESULTS = 6'b010000;
    localparam logic [OP_W-1:0] OPC_START_MULT    = 6'b100000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RSV_HI = 25;
    localparam int RSV_LO = 24;
    localparam int ARG_HI = 23;
    localparam int ARG_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        PAY  = 2'd2
    } state_e;

    function automatic logic [OP_W-1:0] word_op(input logic [WORD_W-1:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction

    // Exactly one opcode bit set and the reserved field clear.
    function automatic logic word_legal(input logic [WORD_W-1:0] w);
        logic [OP_W-1:0] op;
        op = w[OPC_HI:OPC_LO];
        return (op != '0) && ((op & (op - 6'd1)) == '0) && (w[RSV_HI:RSV_LO] == 2'b00);
    endfunction

endpackage

// File: rtl/multiexp_cmd_skid.sv
// Two-entry buffer in front of a non-showahead scfifo; issues rdreq only when the
// returning word is guaranteed a free slot, counting the word the consumer pops this cycle.
module multiexp_cmd_skid
    import multiexp_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_datai,
    input  logic              pop,
    output logic              fifo_rden,
    output logic              head_valid,
    output logic [WORD_W-1:0] head_data,
    output logic              buf_busy
);

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic              run_q;
    logic [WORD_W-1:0] head_q, head_d;
    logic [WORD_W-1:0] tail_q, tail_d;
    logic [2:0]        slots_used;

    assign slots_used = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
    // run_q keeps rdreq low while in reset and on the first edge after it.
    assign fifo_rden  = run_q & ~fifo_empty & (slots_used < 3'd2);
    assign head_valid = (occ_q != 2'd0);
    assign head_data  = head_q;
    assign buf_busy   = (occ_q != 2'd0);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({inflight_q, pop})
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = fifo_datai;
                end else begin
                    head_d = fifo_datai;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_datai;
                end else begin
                    tail_d = fifo_datai;
                end
                occ_d = occ_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rden;
            run_q      <= 1'b1;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: rtl/multiexp_cmd_decode.sv
// Command front end: decodes one-hot opcode words from the PCIe FIFO and forwards LOAD payloads verbatim.
// Define MULTIEXP_CMD_ERRCNT_EN to build the saturating illegal-word counter behind err_count.
module multiexp_cmd_decode
    import multiexp_cmd_pkg::*;
#(
    parameter int unsigned e_words = 16,
    parameter int unsigned t_words = 16
)
(
    input  logic              clk,
    input  logic              pcie_perstn,
    input  logic [WORD_W-1:0] fifo_datai,
    input  logic              fifo_empty,
    output logic              fifo_rden,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [OP_W-1:0]   cmd_op,
    output logic [ARG_W-1:0]  cmd_arg,
    output logic              pay_valid,
    input  logic              pay_ready,
    output logic [WORD_W-1:0] pay_data,
    output logic              pay_last,
    output logic              err_illegal,
    output logic [15:0]       err_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] E_CNT = CNT_W'(e_words);
    localparam logic [CNT_W-1:0] T_CNT = CNT_W'(t_words);

    logic              head_valid, pop, buf_busy, pay_take;
    logic [WORD_W-1:0] head_data;

    state_e            state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [OP_W-1:0]   cmd_op_q, cmd_op_d;
    logic [ARG_W-1:0]  cmd_arg_q, cmd_arg_d;
    logic              pay_valid_q, pay_valid_d;
    logic [WORD_W-1:0] pay_data_q, pay_data_d;
    logic              pay_last_q, pay_last_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              err_illegal_q, err_illegal_d;

    multiexp_cmd_skid u_skid (
        .clk        (clk),
        .rst_n      (pcie_perstn),
        .fifo_empty (fifo_empty),
        .fifo_datai (fifo_datai),
        .pop        (pop),
        .fifo_rden  (fifo_rden),
        .head_valid (head_valid),
        .head_data  (head_data),
        .buf_busy   (buf_busy)
    );

    assign pay_take = pay_valid_q & pay_ready;

    always_comb begin
        state_d       = state_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_op_d      = cmd_op_q;
        cmd_arg_d     = cmd_arg_q;
        pay_valid_d   = pay_valid_q;
        pay_data_d    = pay_data_q;
        pay_last_d    = pay_last_q;
        rem_d         = rem_q;
        err_illegal_d = 1'b0;
        pop           = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_valid) begin
                    pop = 1'b1;
                    if (word_legal(head_data)) begin
                        cmd_op_d    = word_op(head_data);
                        cmd_arg_d   = head_data[ARG_HI:ARG_LO];
                        cmd_valid_d = 1'b1;
                        state_d     = CMD;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (cmd_op_q[OP_LOAD_ERAM]) begin
                        rem_d   = E_CNT;
                        state_d = PAY;
                    end else if (cmd_op_q[OP_LOAD_TRAM]) begin
                        rem_d   = T_CNT;
                        state_d = PAY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            PAY: begin
                // rem_q counts words not yet loaded into the output register.
                if (pay_take) begin
                    pay_valid_d = 1'b0;
                    pay_last_d  = 1'b0;
                end
                if (pay_take && pay_last_q) begin
                    state_d = IDLE;
                end else if (head_valid && (rem_q != '0) && (!pay_valid_q || pay_ready)) begin
                    pop         = 1'b1;
                    pay_valid_d = 1'b1;
                    pay_data_d  = head_data;
                    pay_last_d  = (rem_q == CNT_W'(1));
                    rem_d       = rem_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge pcie_perstn) begin
        if (!pcie_perstn) begin
            state_q       <= IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= '0;
            cmd_arg_q     <= '0;
            pay_valid_q   <= 1'b0;
            pay_data_q    <= '0;
            pay_last_q    <= 1'b0;
            rem_q         <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_op_q      <= cmd_op_d;
            cmd_arg_q     <= cmd_arg_d;
            pay_valid_q   <= pay_valid_d;
            pay_data_q    <= pay_data_d;
            pay_last_q    <= pay_last_d;
            rem_q         <= rem_d;
            err_illegal_q <= err_illegal_d;
        end
    end

`ifdef MULTIEXP_CMD_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_illegal_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge pcie_perstn) begin
        if (!pcie_perstn) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'd0;
`endif

    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_arg     = cmd_arg_q;
    assign pay_valid   = pay_valid_q;
    assign pay_data    = pay_data_q;
    assign pay_last    = pay_last_q;
    assign err_illegal = err_illegal_q;
    assign busy        = (state_q != IDLE) | buf_busy;

endmodule

// File: tb/tb_multiexp_cmd_decode.sv
// Scoreboard bench for multiexp_cmd_decode: stimulus queues expected transfers, a negedge monitor checks them.
// Expects err_count to be live only when MULTIEXP_CMD_ERRCNT_EN is defined.
module tb_multiexp_cmd_decode;

    logic        clk = 1'b0;
    logic        pcie_perstn;
    logic [31:0] fifo_datai = '0;
    logic        fifo_empty;
    logic        fifo_rden;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  cmd_op;
    logic [23:0] cmd_arg;
    logic        pay_valid, pay_ready;
    logic [31:0] pay_data;
    logic        pay_last;
    logic        err_illegal;
    logic [15:0] err_count;
    logic        busy;

    always #5 clk = ~clk;

    multiexp_cmd_decode #(.e_words(16), .t_words(16)) dut (
        .clk         (clk),
        .pcie_perstn (pcie_perstn),
        .fifo_datai  (fifo_datai),
        .fifo_empty  (fifo_empty),
        .fifo_rden   (fifo_rden),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_data    (pay_data),
        .pay_last    (pay_last),
        .err_illegal (err_illegal),
        .err_count   (err_count),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    // scfifo model: one-cycle read latency, flushed while reset is low.
    logic [31:0] fmem [0:255];
    int wr_idx = 0;
    int rd_idx = 0;
    int uflow_cnt = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (!pcie_perstn) begin
            rd_idx <= wr_idx;
        end else if (fifo_rden) begin
            if (rd_idx == wr_idx) begin
                uflow_cnt <= uflow_cnt + 1;
            end else begin
                fifo_datai <= fmem[rd_idx];
                rd_idx     <= rd_idx + 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [29:0] cmd_exp [$];
    logic [32:0] pay_exp [$];

    function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compares every handshake against the scoreboard and checks hold-under-stall.
    int          err_seen = 0;
    bit          cmd_stall_prev = 0;
    bit          pay_stall_prev = 0;
    logic [29:0] cmd_prev;
    logic [32:0] pay_prev;
    int          last_pay_cyc = -10;
    int          streak = 0;
    int          last_streak = 0;

    always @(negedge clk) begin
        if (!pcie_perstn) begin
            cmd_stall_prev = 0;
            pay_stall_prev = 0;
        end else begin
            if (cmd_valid && pay_valid) chk(0, "chan_overlap", 1, 0);
            if (cmd_stall_prev) chk(cmd_valid && ({cmd_op, cmd_arg} == cmd_prev), "cmd_hold", {cmd_valid, cmd_op, cmd_arg}, {1'b1, cmd_prev});
            if (pay_stall_prev) chk(pay_valid && ({pay_last, pay_data} == pay_prev), "pay_hold", {pay_valid, pay_last, pay_data}, {1'b1, pay_prev});
            if (cmd_valid && cmd_ready) begin
                if (cmd_exp.size() == 0) begin
                    chk(0, "cmd_unexpected", {cmd_op, cmd_arg}, 0);
                end else begin
                    chk({cmd_op, cmd_arg} == cmd_exp[0], "cmd", {cmd_op, cmd_arg}, cmd_exp[0]);
                    void'(cmd_exp.pop_front());
                end
            end
            if (pay_valid && pay_ready) begin
                if (pay_exp.size() == 0) begin
                    chk(0, "pay_unexpected", {pay_last, pay_data}, 0);
                end else begin
                    chk({pay_last, pay_data} == pay_exp[0], "pay", {pay_last, pay_data}, pay_exp[0]);
                    void'(pay_exp.pop_front());
                end
                streak       = (last_pay_cyc == cyc - 1) ? streak + 1 : 1;
                last_pay_cyc = cyc;
                if (pay_last) last_streak = streak;
            end
            if (err_illegal) err_seen++;
            cmd_stall_prev = cmd_valid && !cmd_ready;
            pay_stall_prev = pay_valid && !pay_ready;
            cmd_prev       = {cmd_op, cmd_arg};
            pay_prev       = {pay_last, pay_data};
        end
    end

    task automatic push_word(input logic [31:0] w);
        fmem[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic exp_cmd(input logic [5:0] op, input logic [23:0] arg);
        cmd_exp.push_back({op, arg});
    endtask

    task automatic load_cmd(input logic [31:0] cmd, input logic [31:0] base);
        push_word(cmd);
        exp_cmd(cmd[31:26], cmd[23:0]);
        for (int i = 0; i < 16; i++) begin
            push_word(base + 32'(i));
            pay_exp.push_back({(i == 15), base + 32'(i)});
        end
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            done = (cmd_exp.size() == 0) && (pay_exp.size() == 0) && !busy && fifo_empty;
        end
        chk(done, name, {cmd_exp.size(), pay_exp.size()}, 0);
    endtask

    int err_base;

    initial begin
        pcie_perstn = 1'b0;
        cmd_ready   = 1'b1;
        pay_ready   = 1'b1;
        @(negedge clk);
        chk({cmd_valid, pay_valid, pay_last, err_illegal, busy, fifo_rden, cmd_op, cmd_arg, pay_data, err_count} == '0,
            "reset_state", {cmd_valid, pay_valid, pay_last, err_illegal, busy, fifo_rden, cmd_op}, 0);
        repeat (2) @(posedge clk);
        #1 pcie_perstn = 1'b1;

        // SET_ADDR with the command channel stalled for several cycles
        cmd_ready = 1'b0;
        push_word(32'h1000_0005);
        exp_cmd(6'b000100, 24'h000005);
        repeat (6) @(posedge clk);
        #1 cmd_ready = 1'b1;
        drain("set_addr_drain", 50);
        $display("txn set_addr done total=%0d", total);

        // LOAD_TRAM whose payload looks like SET_ADDR words
        load_cmd(32'h0810_0000, 32'h1000_0000);
        drain("load_tram_drain", 100);
        $display("txn load_tram done total=%0d", total);

        // Back-to-back LOAD_TRAM + START_MULT, full-rate payload
        load_cmd(32'h0800_0000, 32'hA000_0000);
        push_word(32'h8000_0000);
        exp_cmd(6'b100000, 24'h0);
        drain("b2b_drain", 100);
        chk(last_streak == 16, "b2b_throughput", last_streak, 16);
        $display("txn back_to_back done total=%0d", total);

        // LOAD_ERAM with pay_ready toggling every cycle
        load_cmd(32'h0400_0000, 32'h5A5A_0000);
        for (int i = 0; i < 200 && (pay_exp.size() != 0 || cmd_exp.size() != 0); i++) begin
            @(posedge clk);
            #1 pay_ready = ~pay_ready;
        end
        pay_ready = 1'b1;
        drain("backpressure_drain", 50);
        chk(uflow_cnt == 0, "fifo_underflow", uflow_cnt, 0);
        $display("txn backpressure done total=%0d", total);

        // Two illegal words then FLUSH_RESULTS
        err_base = err_seen;
        push_word(32'h0300_0000);
        push_word(32'h1800_0000);
        push_word(32'h4000_0000);
        exp_cmd(6'b010000, 24'h0);
        drain("illegal_drain", 50);
        chk(err_seen - err_base == 2, "err_pulses", err_seen - err_base, 2);
`ifdef MULTIEXP_CMD_ERRCNT_EN
        chk(err_count == 16'd2, "err_count", err_count, 2);
`else
        chk(err_count == 16'd0, "err_count", err_count, 0);
`endif
        $display("txn illegal done total=%0d", total);

        // Reset after 5 of 16 LOAD_ERAM payload words
        load_cmd(32'h0400_0000, 32'h7700_0000);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(posedge clk);
                #1;
                if (pay_exp.size() == 11) begin
                    pay_ready = 1'b0;
                    hit = 1;
                end
            end
            chk(hit, "reset_setup", pay_exp.size(), 11);
        end
        @(posedge clk);
        #1 pcie_perstn = 1'b0;
        #1;
        chk({cmd_valid, pay_valid, pay_last, err_illegal, busy, fifo_rden, cmd_op, cmd_arg, pay_data, err_count} == '0,
            "reset_mid_outputs", {cmd_valid, pay_valid, pay_last, busy, fifo_rden, pay_data}, 0);
        pay_exp.delete();
        repeat (3) @(posedge clk);
        #1 pcie_perstn = 1'b1;
        pay_ready = 1'b1;
        push_word(32'h2000_0001);
        exp_cmd(6'b001000, 24'h000001);
        drain("post_reset_drain", 50);
        chk(err_count == 16'd0, "err_count_after_reset", err_count, 0);
        chk(uflow_cnt == 0, "fifo_underflow_final", uflow_cnt, 0);
        $display("txn reset_mid done total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
